// File: rtl/seq_pattern_detector_if.sv
// Configuration, serial-data and status bundle for seq_pattern_detector.
// The master side programs the pattern and feeds bits. The slave side is the
// detector, which drives the match and status outputs.
interface seq_pattern_detector_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int COUNT_W = 8
) ();

  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               in_bit;
  logic               clr_count;
  logic               detected;
  logic [COUNT_W-1:0] match_count;
  logic               count_sat;
  logic               armed;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    output in_valid, in_bit, clr_count,
    input  detected, match_count, count_sat, armed
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    input  in_valid, in_bit, clr_count,
    output detected, match_count, count_sat, armed
  );

endinterface

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial bit-pattern detector.
// Bits shift into a history register, MSB-first relative to the pattern.
// A match pulses 'detected' one cycle after the completing bit and bumps a
// saturating counter. Overlapping or restart-after-match behaviour is
// selectable. Out of reset the block searches for 3'b110 with overlap on.
module seq_pattern_detector #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int COUNT_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  seq_pattern_detector_if.slave bus
);

  typedef enum logic [1:0] {
    ST_DIS   = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0]   LenMax   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W:0]     FillOne  = (LEN_W+1)'(1);
  localparam logic [COUNT_W-1:0] CountOne = COUNT_W'(1);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               detected_q, detected_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               sat_q, sat_d;
  logic               armed_q, armed_d;

  logic [LEN_W-1:0]   len_clamp;
  logic [MAX_LEN-1:0] new_hist;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     fill_inc;
  logic               match;

  // Match evaluation on the incoming bit, against the active configuration.
  always_comb begin
    len_clamp = (bus.cfg_len > LenMax) ? LenMax : bus.cfg_len;
    new_hist  = {hist_q[MAX_LEN-2:0], bus.in_bit};
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    fill_inc = {1'b0, fill_q} + FillOne;
    match    = bus.in_valid && (state_q != ST_DIS) &&
               (fill_inc >= {1'b0, len_q}) &&
               (((new_hist ^ pat_q) & len_mask) == '0);
  end

  // Next-state logic: reconfiguration, history shift, FSM and counter.
  always_comb begin
    // NOTE: every _d takes its hold value first, so no path leaves a latch.
    state_d    = state_q;
    pat_d      = pat_q;
    len_d      = len_q;
    ovl_d      = ovl_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    detected_d = 1'b0;
    count_d    = count_q;
    sat_d      = sat_q;

    if (bus.cfg_load) begin
      // Reconfiguration wins over any bit or clear arriving on the same edge.
      pat_d   = bus.cfg_pattern;
      len_d   = len_clamp;
      ovl_d   = bus.cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      count_d = '0;
      sat_d   = 1'b0;
      state_d = (len_clamp == '0) ? ST_DIS : ST_FILL;
    end else begin
      if (bus.in_valid && (state_q != ST_DIS)) begin
        hist_d = new_hist;
        fill_d = (fill_q < LenMax) ? fill_inc[LEN_W-1:0] : fill_q;
        if (match) begin
          detected_d = 1'b1;
          if (count_q != '1) begin
            count_d = count_q + CountOne;
            if (count_d == '1) begin
              sat_d = 1'b1;
            end
          end
        end
        if (match && !ovl_q) begin
          // Non-overlapping: the next match must be built from fresh bits.
          hist_d  = '0;
          fill_d  = '0;
          state_d = ST_FILL;
        end else begin
          state_d = (fill_d >= len_q) ? ST_ARMED : ST_FILL;
        end
      end
      // A clear takes priority over a same-cycle increment.
      if (bus.clr_count) begin
        count_d = '0;
        sat_d   = 1'b0;
      end
    end

    armed_d = (state_d == ST_ARMED);
  end

  // State and registered outputs; reset restores the default 110 search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the active configuration is reset to a usable default rather
      // than left unknown, so the block detects 110 without any setup.
      state_q    <= ST_FILL;
      pat_q      <= MAX_LEN'(3'b110);
      len_q      <= LEN_W'(3);
      ovl_q      <= 1'b1;
      hist_q     <= '0;
      fill_q     <= '0;
      detected_q <= 1'b0;
      count_q    <= '0;
      sat_q      <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      ovl_q      <= ovl_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      detected_q <= detected_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
      armed_q    <= armed_d;
    end
  end

  assign bus.detected    = detected_q;
  assign bus.match_count = count_q;
  assign bus.count_sat   = sat_q;
  assign bus.armed       = armed_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector. A default-width instance covers
// pattern behaviour. A COUNT_W=2 instance covers counter saturation.
module tb_seq_pattern_detector;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  seq_pattern_detector_if #(.MAX_LEN(8), .LEN_W(4), .COUNT_W(8)) bus ();
  seq_pattern_detector_if #(.MAX_LEN(8), .LEN_W(4), .COUNT_W(2)) sbus ();

  seq_pattern_detector #(.MAX_LEN(8), .LEN_W(4), .COUNT_W(8)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  seq_pattern_detector #(.MAX_LEN(8), .LEN_W(4), .COUNT_W(2)) u_small (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sbus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock on the main instance. Strobes last one edge only.
  task automatic drive(input logic load, input logic clr, input logic valid, input logic b);
    @(negedge clk);
    bus.cfg_load  = load;
    bus.clr_count = clr;
    bus.in_valid  = valid;
    bus.in_bit    = b;
    @(posedge clk);
    #1;
    bus.cfg_load  = 1'b0;
    bus.clr_count = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Stream n valid bits, bits[n-1] first. Check detected after each bit.
  task automatic stream(input string tag, input logic [15:0] bits, input int n,
                        input logic [15:0] exp_det);
    for (int i = n - 1; i >= 0; i--) begin
      drive(1'b0, 1'b0, 1'b1, bits[i]);
      check($sformatf("%s_det_b%0d", tag, n - i), bus.detected, exp_det[i]);
    end
  endtask

  initial begin
    int exp_cnt[4] = '{1, 2, 3, 3};
    int exp_sat[4] = '{0, 0, 1, 1};

    bus.cfg_load = 0; bus.cfg_pattern = 0; bus.cfg_len = 0; bus.cfg_overlap = 0;
    bus.in_valid = 0; bus.in_bit = 0; bus.clr_count = 0;
    sbus.cfg_load = 0; sbus.cfg_pattern = 0; sbus.cfg_len = 0; sbus.cfg_overlap = 0;
    sbus.in_valid = 0; sbus.in_bit = 0; sbus.clr_count = 0;
    rst_n = 1'b0;
    #12;
    check("rst_detected", bus.detected, 0);
    check("rst_count", bus.match_count, 0);
    check("rst_sat", bus.count_sat, 0);
    check("rst_armed", bus.armed, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default 110 with overlap: stream 1101100.
    stream("def", 16'b11, 2, 16'b00);
    check("def_armed_b2", bus.armed, 0);
    stream("def3", 16'b0, 1, 16'b1);
    check("def_armed_b3", bus.armed, 1);
    stream("def4", 16'b1100, 4, 16'b0010);
    check("def_count", bus.match_count, 2);

    // 0101 overlapping, then non-overlapping.
    load_cfg(8'b0101, 4'd4, 1'b1);
    check("ovl_load_count", bus.match_count, 0);
    check("ovl_load_armed", bus.armed, 0);
    stream("ovl", 16'b0101010, 7, 16'b0001010);
    check("ovl_count", bus.match_count, 2);
    load_cfg(8'b0101, 4'd4, 1'b0);
    stream("novl", 16'b0101010, 7, 16'b0001000);
    check("novl_count", bus.match_count, 1);
    check("novl_armed", bus.armed, 0);

    // in_valid gaps with default pattern: 1, gap x3, 1, gap, 0.
    load_cfg(8'b110, 4'd3, 1'b1);
    drive(0, 0, 1, 1); check("gap_b1", bus.detected, 0);
    for (int g = 0; g < 3; g++) begin
      drive(0, 0, 0, 0); check($sformatf("gap_idle%0d", g), bus.detected, 0);
    end
    drive(0, 0, 1, 1); check("gap_b2", bus.detected, 0);
    drive(0, 0, 0, 0); check("gap_idle3", bus.detected, 0);
    drive(0, 0, 1, 0); check("gap_b3", bus.detected, 1);
    drive(0, 0, 0, 0); check("gap_after", bus.detected, 0);
    check("gap_count", bus.match_count, 1);

    // cfg_load coincident with the completing bit: bit dropped, history cleared.
    stream("ldc", 16'b11, 2, 16'b00);
    drive(1, 0, 1, 0);
    check("ldc_det", bus.detected, 0);
    check("ldc_count", bus.match_count, 0);
    check("ldc_armed", bus.armed, 0);
    stream("ldc_post", 16'b0, 1, 16'b0);

    // clr_count coincident with a match.
    stream("clr_pre", 16'b110, 3, 16'b001);
    check("clr_pre_count", bus.match_count, 1);
    stream("clr", 16'b11, 2, 16'b00);
    drive(0, 1, 1, 0);
    check("clr_det", bus.detected, 1);
    check("clr_count", bus.match_count, 0);
    check("clr_sat", bus.count_sat, 0);

    // len=0 disables detection.
    load_cfg(8'b110, 4'd0, 1'b1);
    stream("dis", 16'b110110, 6, 16'b0);
    check("dis_armed", bus.armed, 0);
    check("dis_count", bus.match_count, 0);

    // len=15 clamps to 8.
    load_cfg(8'hA5, 4'd15, 1'b1);
    stream("clamp", 16'hA5, 8, 16'b0000_0001);
    check("clamp_count", bus.match_count, 1);
    check("clamp_armed", bus.armed, 1);

    // COUNT_W=2 saturation on the small instance.
    @(negedge clk);
    sbus.cfg_pattern = 8'h01; sbus.cfg_len = 4'd1; sbus.cfg_overlap = 1'b1;
    sbus.cfg_load = 1'b1;
    @(negedge clk);
    sbus.cfg_load = 1'b0;
    sbus.in_valid = 1'b1; sbus.in_bit = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("sat_det%0d", k), sbus.detected, 1);
      check($sformatf("sat_cnt%0d", k), sbus.match_count, exp_cnt[k]);
      check($sformatf("sat_flag%0d", k), sbus.count_sat, exp_sat[k]);
    end
    @(negedge clk);
    sbus.in_valid = 1'b0; sbus.clr_count = 1'b1;
    @(posedge clk); #1;
    sbus.clr_count = 1'b0;
    check("sat_clr_cnt", sbus.match_count, 0);
    check("sat_clr_flag", sbus.count_sat, 0);

    // Async reset mid-stream restores the default 110 search.
    load_cfg(8'b0101, 4'd4, 1'b1);
    stream("ar_pre", 16'b0101, 4, 16'b0001);
    #2 rst_n = 1'b0;
    #1;
    check("ar_det", bus.detected, 0);
    check("ar_count", bus.match_count, 0);
    check("ar_armed", bus.armed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stream("ar_post", 16'b110, 3, 16'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
